// File: rtl/exp5_detector_jogada_pkg.sv
// Shared FSM state codes and helpers for the play detector.
// The debug 7-segment decoder depends on these exact encodings.
package exp5_detector_jogada_pkg;

  typedef enum logic [1:0] {
    OCIOSO = 2'b00,
    FILTRA = 2'b01,
    PULSO  = 2'b10,
    SOLTA  = 2'b11
  } estado_t;

  // Returns true only when exactly one button is pressed.
  function automatic logic one_hot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/exp5_detector_jogada_contador_m.sv
// Modulo-M counter with synchronous clear and enable.
// It saturates at M-1 and never wraps; o_fim flags the terminal count.
module contador_m #(
  parameter int M = 4,
  parameter int W = 2
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_zera,
  input  logic i_conta,
  output logic o_fim
);

  logic [W-1:0] r_q;

  assign o_fim = (r_q == W'(M - 1));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)                 r_q <= '0;
    else if (i_zera)             r_q <= '0;
    else if (i_conta && !o_fim)  r_q <= r_q + W'(1);
  end

endmodule

// File: rtl/exp5_detector_jogada.sv
// Turns the four raw player buttons into a debounced one-cycle play pulse plus a held one-hot code.
// It also runs the play timeout that drives fimTempo.
module exp5_detector_jogada
  import exp5_detector_jogada_pkg::*;
#(
  parameter int DEBOUNCE = 50000,
  parameter int TIMEOUT  = 150000000,
  parameter int WT       = 28
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes,
  input  logic       zeraT,
  input  logic       contaT,
  output logic       jogada,
  output logic [3:0] botao_reg,
  output logic       fimTempo,
  output logic [1:0] db_estado
);

  localparam int WD = $clog2(DEBOUNCE);

  logic [3:0] r_sync1, r_sync2, r_cand, r_botao;
  logic       r_fim;
  estado_t    r_estado, w_prox;
  logic [3:0] w_bs;
  logic       w_db_zera, w_db_conta, w_db_fim, w_carrega, w_t_fim;

  assign w_bs = r_sync2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= 4'b0000;
      r_sync2 <= 4'b0000;
    end else begin
      r_sync1 <= botoes;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado <= OCIOSO;
      r_cand   <= 4'b0000;
      r_botao  <= 4'b0000;
    end else begin
      r_estado <= w_prox;
      if (r_estado == OCIOSO && w_bs != 4'b0000) r_cand <= w_bs;
      if (w_carrega) r_botao <= r_cand;
    end
  end

  // The debounce count restarts on every state change, and in SOLTA on any nonzero input.
  always_comb begin
    w_prox     = r_estado;
    w_db_conta = 1'b0;
    w_carrega  = 1'b0;
    case (r_estado)
      OCIOSO: if (w_bs != 4'b0000) w_prox = FILTRA;
      FILTRA: begin
        if (w_bs != r_cand) w_prox = OCIOSO;
        else if (w_db_fim) begin
          if (one_hot4(r_cand)) begin
            w_prox    = PULSO;
            w_carrega = 1'b1;
          end else begin
            w_prox = SOLTA;
          end
        end else w_db_conta = 1'b1;
      end
      PULSO:  w_prox = SOLTA;
      SOLTA: begin
        if (w_bs == 4'b0000) begin
          if (w_db_fim) w_prox = OCIOSO;
          else          w_db_conta = 1'b1;
        end
      end
      default: w_prox = OCIOSO;
    endcase
    w_db_zera = (w_prox != r_estado) || (r_estado == SOLTA && w_bs != 4'b0000);
  end

  contador_m #(.M(DEBOUNCE), .W(WD)) u_debounce (
    .i_clock (clock),
    .i_reset (reset),
    .i_zera  (w_db_zera),
    .i_conta (w_db_conta),
    .o_fim   (w_db_fim)
  );

  contador_m #(.M(TIMEOUT), .W(WT)) u_timeout (
    .i_clock (clock),
    .i_reset (reset),
    .i_zera  (zeraT),
    .i_conta (contaT && !r_fim),
    .o_fim   (w_t_fim)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                  r_fim <= 1'b0;
    else if (zeraT)             r_fim <= 1'b0;
    else if (contaT && w_t_fim) r_fim <= 1'b1;
  end

  assign jogada    = (r_estado == PULSO);
  assign botao_reg = r_botao;
  assign fimTempo  = r_fim;
  assign db_estado = r_estado;

endmodule

// File: tb/tb_exp5_detector_jogada.sv
// Directed bench for the play detector with a cycle-level reference model built from input history.
module tb_exp5_detector_jogada;

  localparam int DB = 4;
  localparam int TO = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] botoes = 4'b0000;
  logic       zeraT = 1'b0;
  logic       contaT = 1'b0;
  logic       jogada, fimTempo;
  logic [3:0] botao_reg;
  logic [1:0] db_estado;

  exp5_detector_jogada #(.DEBOUNCE(DB), .TIMEOUT(TO), .WT(5)) dut (
    .clock(clock), .reset(reset), .botoes(botoes), .zeraT(zeraT), .contaT(contaT),
    .jogada(jogada), .botao_reg(botao_reg), .fimTempo(fimTempo), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: b_s is the pin value two edges late. A press is accepted when one
  // nonzero value is seen on DB+1 consecutive samples from idle; afterwards the detector
  // is deaf until DB consecutive zero samples arrive. Timeout = total enabled cycles since clear.
  logic [3:0] m_s1, m_s2, m_val, m_botao;
  logic       m_jog, m_trk, m_rel;
  int         m_seen, m_zeros, m_tacc;

  task automatic model_clear();
    m_s1 = 0; m_s2 = 0; m_val = 0; m_botao = 0;
    m_jog = 0; m_trk = 0; m_rel = 0;
    m_seen = 0; m_zeros = 0; m_tacc = 0;
  endtask

  task automatic model_edge();
    logic [3:0] s;
    if (reset) begin model_clear(); return; end
    s = m_s2; m_s2 = m_s1; m_s1 = botoes;
    if (zeraT) m_tacc = 0;
    else if (contaT && m_tacc < 1000) m_tacc++;
    if (m_jog) begin
      m_jog = 0; m_rel = 1; m_zeros = 0;
    end else if (m_rel) begin
      m_zeros = (s == 0) ? m_zeros + 1 : 0;
      if (m_zeros == DB) m_rel = 0;
    end else if (m_trk) begin
      if (s != m_val) m_trk = 0;
      else begin
        m_seen++;
        if (m_seen == DB + 1) begin
          m_trk = 0;
          if ($countones(m_val) == 1) begin m_jog = 1; m_botao = m_val; end
          else begin m_rel = 1; m_zeros = 0; end
        end
      end
    end else if (s != 0) begin
      m_trk = 1; m_val = s; m_seen = 1;
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clock or posedge reset);
      model_edge();
    end
  end

  // Per-cycle compare plus event bookkeeping for the literal checks.
  int   n_pulse = 0, last_pulse = -1, fim_rise = -1;
  logic prev_fim = 1'b0, seen_solta = 1'b0;
  initial forever begin
    logic [1:0] m_est;
    @(negedge clock);
    m_est = m_jog ? 2'd2 : m_rel ? 2'd3 : m_trk ? 2'd1 : 2'd0;
    check("jogada", jogada, m_jog);
    check("botao_reg", botao_reg, m_botao);
    check("fimTempo", fimTempo, (m_tacc >= TO));
    check("db_estado", db_estado, m_est);
    if (jogada) begin n_pulse++; last_pulse = cyc; end
    if (fimTempo && !prev_fim) fim_rise = cyc;
    prev_fim = fimTempo;
    if (db_estado == 2'd3) seen_solta = 1'b1;
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  initial begin
    int c0, p0;
    logic found;
    cyc_wait(2);
    check("rst_jogada", jogada, 0);
    check("rst_botao", botao_reg, 0);
    check("rst_estado", db_estado, 0);
    check("rst_fim", fimTempo, 0);
    reset = 1'b0;
    cyc_wait(2);

    // 1: clean press of 0100
    c0 = cyc; p0 = n_pulse; botoes = 4'b0100;
    cyc_wait(10); botoes = 4'b0000; cyc_wait(12);
    check("t1_pulses", n_pulse - p0, 1);
    check("t1_latency", last_pulse - c0, 7);
    check("t1_botao", botao_reg, 4'b0100);
    check("t1_idle", db_estado, 0);

    // 2: bouncing 0001 then stable hold
    p0 = n_pulse;
    for (int i = 0; i < 5; i++) begin
      botoes = 4'b0001; cyc_wait(2); botoes = 4'b0000; cyc_wait(2);
    end
    check("t2_bounce_pulses", n_pulse - p0, 0);
    botoes = 4'b0001; cyc_wait(10); botoes = 4'b0000; cyc_wait(12);
    check("t2_pulses", n_pulse - p0, 1);
    check("t2_botao", botao_reg, 4'b0001);

    // 3: multi-press is rejected
    p0 = n_pulse; seen_solta = 1'b0;
    botoes = 4'b0011; cyc_wait(10); botoes = 4'b0000; cyc_wait(12);
    check("t3_pulses", n_pulse - p0, 0);
    check("t3_botao", botao_reg, 4'b0001);
    check("t3_solta", seen_solta, 1);

    // 4: timeout, plain then with a 5-cycle pause (edge after zeraT is the reference)
    c0 = cyc; zeraT = 1'b1; cyc_wait(1); zeraT = 1'b0; contaT = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin @(negedge clock); found = fimTempo; end
    check("t4_fim_reached", found, 1);
    check("t4_fim_delay", fim_rise - (c0 + 1), 20);
    cyc_wait(5);
    check("t4_fim_hold", fimTempo, 1);
    zeraT = 1'b1; cyc_wait(1); zeraT = 1'b0;
    check("t4_fim_clear", fimTempo, 0);
    contaT = 1'b0; cyc_wait(2);
    c0 = cyc; zeraT = 1'b1; cyc_wait(1); zeraT = 1'b0; contaT = 1'b1;
    cyc_wait(8); contaT = 1'b0; cyc_wait(5); contaT = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin @(negedge clock); found = fimTempo; end
    check("t4p_fim_reached", found, 1);
    check("t4p_fim_delay", fim_rise - (c0 + 1), 25);
    #1; contaT = 1'b0; zeraT = 1'b1; cyc_wait(1); zeraT = 1'b0; cyc_wait(2);

    // 5: long hold, then release windows of 3 and 4 cycles
    p0 = n_pulse; botoes = 4'b1000; cyc_wait(100);
    check("t5_long_pulses", n_pulse - p0, 1);
    check("t5_botao", botao_reg, 4'b1000);
    p0 = n_pulse;
    botoes = 4'b0000; cyc_wait(3); botoes = 4'b0010; cyc_wait(10);
    check("t5_short_release", n_pulse - p0, 0);
    botoes = 4'b0000; cyc_wait(4); botoes = 4'b0100; cyc_wait(10);
    check("t5_after_release", n_pulse - p0, 1);
    check("t5_botao2", botao_reg, 4'b0100);
    botoes = 4'b0000; cyc_wait(12);

    // 6: reset in FILTRA and in PULSO
    botoes = 4'b0001; cyc_wait(4);
    check("t6_in_filtra", db_estado, 1);
    reset = 1'b1; #1;
    check("t6a_estado", db_estado, 0);
    check("t6a_botao", botao_reg, 0);
    check("t6a_jogada", jogada, 0);
    cyc_wait(2); reset = 1'b0; p0 = n_pulse;
    cyc_wait(2);
    check("t6a_no_early_pulse", n_pulse - p0, 0);
    cyc_wait(10); botoes = 4'b0000; cyc_wait(12);
    check("t6a_late_pulse", n_pulse - p0, 1);
    botoes = 4'b0010; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin @(negedge clock); found = (db_estado == 2'd2); end
    check("t6b_reach_pulso", found, 1);
    #1; reset = 1'b1; #1;
    check("t6b_jogada", jogada, 0);
    check("t6b_botao", botao_reg, 0);
    check("t6b_estado", db_estado, 0);
    cyc_wait(2); reset = 1'b0; p0 = n_pulse;
    cyc_wait(2);
    check("t6b_no_early_pulse", n_pulse - p0, 0);
    botoes = 4'b0000; cyc_wait(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
